// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types: multiplier FSM state and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row counter only needs to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_row_adder.sv
// One partial-product row: acc_hi + (en ? m : 0) as a ripple of 1-bit full adders.
module mult_row_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] m,
  input  logic             en,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   carry;

  assign addend   = en ? m : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = acc_hi[i] ^ addend[i] ^ carry[i];
    assign carry[i+1] = (acc_hi[i] & addend[i]) | (carry[i] & (acc_hi[i] ^ addend[i]));
  end

  assign sum[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial-product row per clock
// through a shared row adder, valid/ready on both operand and product sides.
module seq_array_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   min,
  input  logic [WIDTH-1:0]   qin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   m_reg;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     sum;
  logic               last_row;

  mult_row_adder #(.WIDTH(WIDTH)) u_row (
    .acc_hi (acc[2*WIDTH-1:WIDTH]),
    .m      (m_reg),
    .en     (acc[0]),
    .sum    (sum)
  );

  // Low half of acc starts as the multiplier and shifts out one bit per row
  // while product bits shift in from the top.
  assign acc_nxt  = {sum, acc[WIDTH-1:1]};
  assign last_row = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_row)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      m_reg <= '0;
      acc   <= '0;
      p     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          m_reg <= min;
          acc   <= {{WIDTH{1'b0}}, qin};
          cnt   <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last_row) p <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed and seeded-random checks of seq_array_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_array_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  min4, qin4;
  logic [7:0]  p4;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  min8, qin8;
  logic [15:0] p8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_array_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .min(min4), .qin(qin4), .out_valid(out_valid4), .out_ready(out_ready4), .p(p4)
  );

  seq_array_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .min(min8), .qin(qin8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 operation; holds out_ready low for 'hold' DONE cycles while
  // presenting a stray in_valid that must be ignored.
  task automatic run4(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                      input int hold);
    min4 = m; qin4 = q; in_valid4 = 1'b1; out_ready4 = 1'b0;
    check("w4_ready_before_accept", in_ready4, 1);
    tick();
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("w4_busy_run", {out_valid4, in_ready4}, 2'b00);
      tick();
    end
    check("w4_done_valid", {out_valid4, in_ready4}, 2'b10);
    check("w4_product", p4, exp);
    for (int i = 0; i < hold; i++) begin
      min4 = 4'd1; qin4 = 4'd1; in_valid4 = 1'b1;
      tick();
      check("w4_hold_valid", {out_valid4, in_ready4}, 2'b10);
      check("w4_hold_product", p4, exp);
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("w4_idle_after_hs", {out_valid4, in_ready4}, 2'b01);
    check("w4_p_kept", p4, exp);
  endtask

  initial begin
    int c1, c2, to, nres;
    logic [7:0] rm, rq;
    logic got;

    rst_n = 1'b0;
    in_valid4 = 0; out_ready4 = 0; min4 = 0; qin4 = 0;
    in_valid8 = 0; out_ready8 = 0; min8 = 0; qin8 = 0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready4, 1);
    check("rst_out_valid", out_valid4, 0);
    check("rst_p", p4, 0);
    check("rst_p8", p8, 0);

    run4(4'd3, 4'd5, 8'd15, 0);
    run4(4'd15, 4'd15, 8'd225, 0);
    run4(4'd0, 4'd9, 8'd0, 0);
    run4(4'd15, 4'd15, 8'd225, 3);
    // Stray in_valid during the hold must not have started a new operation.
    tick();
    check("w4_no_stray_accept", in_ready4, 1);

    // Reset two edges into RUN discards the 7*7 in flight.
    min4 = 4'd7; qin4 = 4'd7; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_state", {out_valid4, in_ready4}, 2'b01);
    check("midrst_p", p4, 0);
    repeat (6) tick();
    check("midrst_no_output", {out_valid4, in_ready4}, 2'b01);
    run4(4'd6, 4'd7, 8'd42, 0);

    // WIDTH=8 back-to-back with out_ready high: initiation interval 10.
    out_ready8 = 1'b1; min8 = 8'd255; qin8 = 8'd255; in_valid8 = 1'b1;
    tick();
    c1 = cyc;
    min8 = 8'd128; qin8 = 8'd2;
    to = 0;
    while (!out_valid8 && to < 40) begin tick(); to++; end
    check("b2b_timeout1", to < 40, 1);
    check("b2b_p_65025", p8, 16'd65025);
    while (!in_ready8 && to < 40) begin tick(); to++; end
    tick();
    c2 = cyc;
    in_valid8 = 1'b0;
    check("b2b_ii", c2 - c1, 10);
    to = 0;
    while (!out_valid8 && to < 40) begin tick(); to++; end
    check("b2b_timeout2", to < 40, 1);
    check("b2b_p_256", p8, 16'd256);
    tick();
    out_ready8 = 1'b0;

    // Random operands with random gaps and backpressure against min*qin.
    nres = 0;
    for (int n = 0; n < 200; n++) begin
      rm = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) tick();
      min8 = rm; qin8 = rq; in_valid8 = 1'b1;
      to = 0;
      while (!in_ready8 && to < 50) begin tick(); to++; end
      tick();
      in_valid8 = 1'b0;
      got = 1'b0; to = 0;
      while (!got && to < 100) begin
        out_ready8 = 1'($urandom_range(0, 1));
        if (out_valid8 && out_ready8) begin
          check("rand_product", p8, 16'(rm) * 16'(rq));
          got = 1'b1;
          nres++;
        end
        tick();
        to++;
      end
      out_ready8 = 1'b0;
      check("rand_handshake_seen", got, 1);
      check("rand_no_duplicate", {out_valid8, in_ready8}, 2'b01);
    end
    check("rand_result_count", nres, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
